// File: rtl/spi_control_unit.sv
// spi_control_unit
//
// Transaction sequencer for the SPI slave front end. While chip select is low
// it counts received bytes. Each byte produces a one-cycle load strobe for the
// instruction register, the two address registers or the memory write port.
// It also decodes the latched instruction and updates three status flags.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    synchronous, active-high reset
//   cs                       SPI chip select, active low; high ends/aborts a transaction
//   data_valid               one-cycle pulse, a received byte is complete
//   SPI_instruction_reg_in   byte from the deserialiser (not used for decisions)
//   SPI_instruction_reg_out  contents of the instruction register (decode source)
//   SPI_instruction_reg_en   load strobe, instruction register (combinational)
//   SPI_address_MSB_reg_en   load strobe, address MSB register (combinational)
//   SPI_address_LSB_reg_en   load strobe, address LSB register (combinational)
//   write_memory_enable      memory write strobe (combinational)
//   clk_div_ready(_en)       flag value and its registered write pulse
//   input_spike_ready(_en)   flag value and its registered write pulse
//   debug_config_ready(_en)  flag value and its registered write pulse

module spi_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       data_valid,
  input  logic [7:0] SPI_instruction_reg_in,
  input  logic [7:0] SPI_instruction_reg_out,
  output logic       SPI_address_MSB_reg_en,
  output logic       SPI_address_LSB_reg_en,
  output logic       SPI_instruction_reg_en,
  output logic       clk_div_ready,
  output logic       clk_div_ready_en,
  output logic       input_spike_ready,
  output logic       input_spike_ready_en,
  output logic       debug_config_ready,
  output logic       debug_config_ready_en,
  output logic       write_memory_enable
);

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_MEM_WRITE  = 8'h01;
  localparam logic [7:0] OP_CLKDIV_CLR = 8'h04;
  localparam logic [7:0] OP_CLKDIV_SET = 8'h05;
  localparam logic [7:0] OP_SPIKE_CLR  = 8'h06;
  localparam logic [7:0] OP_SPIKE_SET  = 8'h07;
  localparam logic [7:0] OP_DEBUG_CLR  = 8'h08;
  localparam logic [7:0] OP_DEBUG_SET  = 8'h09;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StAddrMsb,
    StAddrLsb,
    StData,
    StDrain
  } state_t;

  state_t state_q;
  logic   accepted;

  // The raw deserialiser byte is only forwarded to the registers outside.
  logic unused_instr_in;
  assign unused_instr_in = ^SPI_instruction_reg_in;

  // Sequencer state plus the registered flag values and their write pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= StIdle;
      clk_div_ready         <= 1'b0;
      clk_div_ready_en      <= 1'b0;
      input_spike_ready     <= 1'b0;
      input_spike_ready_en  <= 1'b0;
      debug_config_ready    <= 1'b0;
      debug_config_ready_en <= 1'b0;
    end else begin
      clk_div_ready_en      <= 1'b0;
      input_spike_ready_en  <= 1'b0;
      debug_config_ready_en <= 1'b0;

      // The instruction was already accepted, so its flag update is not
      // cancelled by cs rising during the decode cycle.
      if (state_q == StDecode) begin
        case (SPI_instruction_reg_out)
          OP_CLKDIV_CLR, OP_CLKDIV_SET: begin
            clk_div_ready    <= SPI_instruction_reg_out[0];
            clk_div_ready_en <= 1'b1;
          end
          OP_SPIKE_CLR, OP_SPIKE_SET: begin
            input_spike_ready    <= SPI_instruction_reg_out[0];
            input_spike_ready_en <= 1'b1;
          end
          OP_DEBUG_CLR, OP_DEBUG_SET: begin
            debug_config_ready    <= SPI_instruction_reg_out[0];
            debug_config_ready_en <= 1'b1;
          end
          default: begin
            // OP_NOP, OP_MEM_WRITE and undefined codes leave the flags alone.
          end
        endcase
      end

      if (cs) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (data_valid) state_q <= StDecode;
          end
          StDecode: begin
            // Bytes arriving here are dropped; the deserialiser cannot
            // produce them this quickly.
            state_q <= (SPI_instruction_reg_out == OP_MEM_WRITE) ? StAddrMsb : StDrain;
          end
          StAddrMsb: begin
            if (data_valid) state_q <= StAddrLsb;
          end
          StAddrLsb: begin
            if (data_valid) state_q <= StData;
          end
          StData: begin
            if (data_valid) state_q <= StDrain;
          end
          StDrain: begin
            state_q <= StDrain;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Load strobes coincide with the accepted byte so the external registers
  // capture it on the same edge. cs high or reset suppresses them.
  always_comb begin
    SPI_instruction_reg_en = 1'b0;
    SPI_address_MSB_reg_en = 1'b0;
    SPI_address_LSB_reg_en = 1'b0;
    write_memory_enable    = 1'b0;
    accepted               = data_valid && !cs && !reset;
    case (state_q)
      StIdle:    SPI_instruction_reg_en = accepted;
      StAddrMsb: SPI_address_MSB_reg_en = accepted;
      StAddrLsb: SPI_address_LSB_reg_en = accepted;
      StData:    write_memory_enable    = accepted;
      default: begin
      end
    endcase
  end

  // OP_NOP is handled by the default decode arm; keep the name referenced.
  logic unused_op_nop;
  assign unused_op_nop = ^OP_NOP;

endmodule

// File: tb/tb_spi_control_unit.sv
module tb_spi_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       data_valid;
  logic [7:0] ins_in;
  logic [7:0] ins_out;
  logic       msb_en, lsb_en, ins_en, wm_en;
  logic       cd, cd_en, sp, sp_en, dbg, dbg_en;

  spi_control_unit dut (
    .clk                     (clk),
    .reset                   (reset),
    .cs                      (cs),
    .data_valid              (data_valid),
    .SPI_instruction_reg_in  (ins_in),
    .SPI_instruction_reg_out (ins_out),
    .SPI_address_MSB_reg_en  (msb_en),
    .SPI_address_LSB_reg_en  (lsb_en),
    .SPI_instruction_reg_en  (ins_en),
    .clk_div_ready           (cd),
    .clk_div_ready_en        (cd_en),
    .input_spike_ready       (sp),
    .input_spike_ready_en    (sp_en),
    .debug_config_ready      (dbg),
    .debug_config_ready_en   (dbg_en),
    .write_memory_enable     (wm_en)
  );

  always #5 clk = ~clk;

  // Strobe vector: {0, ins, msb, lsb, wm, cd_en, sp_en, dbg_en}
  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_INS  = 8'h40;
  localparam logic [7:0] S_MSB  = 8'h20;
  localparam logic [7:0] S_LSB  = 8'h10;
  localparam logic [7:0] S_WM   = 8'h08;
  localparam logic [7:0] S_CD   = 8'h04;
  localparam logic [7:0] S_SP   = 8'h02;
  localparam logic [7:0] S_DBG  = 8'h01;

  logic [7:0] strb;
  logic [7:0] flags;  // {0, clk_div, spike, debug}
  assign strb  = {1'b0, ins_en, msb_en, lsb_en, wm_en, cd_en, sp_en, dbg_en};
  assign flags = {5'b0, cd, sp, dbg};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One data_valid pulse, checked in the cycle it is presented.
  task automatic pulse(input logic [7:0] b, input logic [7:0] exp, input string tag);
    @(negedge clk);
    data_valid = 1'b1;
    ins_in     = b;
    #2 check(tag, strb, exp);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      #2 check("quiet", strb, S_NONE);
      @(negedge clk);
    end
  endtask

  task automatic set_cs(input logic v);
    @(negedge clk);
    cs = v;
  endtask

  // Instruction byte, then the decode cycle and the registered pulse after it.
  task automatic instr(input logic [7:0] b, input logic [7:0] exp_en,
                       input logic [7:0] exp_flags, input string tag);
    pulse(b, S_INS, {tag, "_ins"});
    ins_out = b;
    #2 check({tag, "_dec"}, strb, S_NONE);
    @(negedge clk);
    #2 check({tag, "_en"}, strb, exp_en);
    check({tag, "_flag"}, flags, exp_flags);
    @(negedge clk);
    #2 check({tag, "_en_off"}, strb, S_NONE);
    check({tag, "_hold"}, flags, exp_flags);
    @(negedge clk);
  endtask

  task automatic flag_txn(input logic [7:0] b, input logic [7:0] exp_en,
                          input logic [7:0] exp_flags, input string tag);
    set_cs(1'b0);
    gap(1);
    instr(b, exp_en, exp_flags, tag);
    gap(2);
    set_cs(1'b1);
    gap(2);
    check({tag, "_after_cs"}, flags, exp_flags);
  endtask

  task automatic full_write(input logic [7:0] flg, input string tag);
    instr(8'h01, S_NONE, flg, tag);
    gap(5);
    pulse(8'h12, S_MSB, {tag, "_msb"});
    gap(7);
    pulse(8'h34, S_LSB, {tag, "_lsb"});
    gap(7);
    pulse(8'hAB, S_WM, {tag, "_wr"});
    gap(7);
    pulse(8'hCD, S_NONE, {tag, "_drain"});
  endtask

  initial begin
    reset      = 1'b1;
    cs         = 1'b1;
    data_valid = 1'b0;
    ins_in     = 8'h00;
    ins_out    = 8'h00;
    @(negedge clk);
    @(negedge clk);
    #2 check("in_reset_strb", strb, S_NONE);
    @(negedge clk);
    reset = 1'b0;
    #2 check("rst_strb", strb, S_NONE);
    check("rst_flags", flags, 8'h00);

    // data_valid with cs high is ignored
    pulse(8'h5A, S_NONE, "cs_hi_a");
    pulse(8'h01, S_NONE, "cs_hi_b");

    // Memory write transaction
    set_cs(1'b0);
    gap(2);
    full_write(8'h00, "wr1");
    set_cs(1'b1);
    gap(2);

    // clk_div set, trailing bytes ignored
    set_cs(1'b0);
    gap(1);
    instr(8'h05, S_CD, 8'h04, "cdset");
    gap(5);
    pulse(8'h11, S_NONE, "cd_trail1");
    gap(7);
    pulse(8'h22, S_NONE, "cd_trail2");
    gap(7);
    pulse(8'h33, S_NONE, "cd_trail3");
    set_cs(1'b1);
    gap(3);
    check("cd_kept", flags, 8'h04);

    flag_txn(8'h07, S_SP,  8'h06, "spset");
    flag_txn(8'h09, S_DBG, 8'h07, "dbgset");
    flag_txn(8'h06, S_SP,  8'h05, "spclr");
    flag_txn(8'h08, S_DBG, 8'h04, "dbgclr");

    // NOP: only the instruction strobe
    set_cs(1'b0);
    gap(1);
    instr(8'h00, S_NONE, 8'h04, "nop");
    gap(5);
    pulse(8'h01, S_NONE, "nop_b1");
    gap(7);
    pulse(8'h05, S_NONE, "nop_b2");
    gap(7);
    pulse(8'h09, S_NONE, "nop_b3");
    set_cs(1'b1);
    gap(2);
    check("nop_flags", flags, 8'h04);

    // Aborted write, then a complete one
    set_cs(1'b0);
    gap(1);
    instr(8'h01, S_NONE, 8'h04, "ab");
    gap(5);
    pulse(8'h12, S_MSB, "ab_msb");
    gap(3);
    set_cs(1'b1);
    pulse(8'h34, S_NONE, "ab_lsb_cs_hi");
    pulse(8'hAB, S_NONE, "ab_wr_cs_hi");
    gap(2);
    set_cs(1'b0);
    gap(1);
    full_write(8'h04, "wr2");
    set_cs(1'b1);
    gap(2);

    // Reset mid-transaction (state is waiting for the LSB byte)
    set_cs(1'b0);
    gap(1);
    instr(8'h01, S_NONE, 8'h04, "rm");
    gap(5);
    pulse(8'h12, S_MSB, "rm_msb");
    gap(2);
    reset      = 1'b1;
    data_valid = 1'b1;
    ins_in     = 8'h55;
    #2 check("rm_in_reset", strb, S_NONE);
    @(negedge clk);
    reset      = 1'b0;
    data_valid = 1'b0;
    #2 check("rm_flags", flags, 8'h00);
    check("rm_strb", strb, S_NONE);
    pulse(8'h77, S_INS, "rm_idle");
    set_cs(1'b1);
    gap(3);
    check("end_flags", flags, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
